// File: rtl/dma_wr_arb_if.sv
// Bundle of the NR DMA write-channel beat ports and the shared system-bus write port.
// slave = arbiter side, master = channels/bus side.
interface dma_wr_arb_if #(
    parameter int AW = 32,
    parameter int AL = 2,
    parameter int BL = 3,
    parameter int DW = 8*(2**AL),
    parameter int NR = 2
);
    logic [NR-1:0]          m_wval;
    logic [NR-1:0]          m_wrdy;
    logic [NR*(BL+1)-1:0]   m_wlen;
    logic [NR*AW-1:0]       m_waddr;
    logic [NR*DW-1:0]       m_wdata;
    logic                   bus_wrdy;
    logic                   bus_wval;
    logic [BL:0]            bus_wlen;
    logic [AW-1:0]          bus_waddr;
    logic [DW-1:0]          bus_wdata;

    modport slave (
        input  m_wval, m_wlen, m_waddr, m_wdata, bus_wrdy,
        output m_wrdy, bus_wval, bus_wlen, bus_waddr, bus_wdata
    );

    modport master (
        output m_wval, m_wlen, m_waddr, m_wdata, bus_wrdy,
        input  m_wrdy, bus_wval, bus_wlen, bus_waddr, bus_wdata
    );
endinterface

// File: rtl/dma_wr_arb.sv
// Burst-granular write-port arbiter for NR DMA write channels; round-robin by default,
// strict lowest-index priority when DMA_WR_ARB_PRIO_EN is defined.
module dma_wr_arb #(
    parameter int AW = 32,
    parameter int AL = 2,
    parameter int BL = 3,
    parameter int DW = 8*(2**AL),
    parameter int NR = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    dma_wr_arb_if.slave     arb_if,
    output logic [NR-1:0]   arb_gnt,
    output logic            arb_busy,
    output logic            arb_err
);
    localparam int LW = BL + 1;
    localparam int IW = (NR > 1) ? $clog2(NR) : 1;

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    state_t         r_state;
    logic [NR-1:0]  r_gnt;
    logic [IW-1:0]  r_gidx;
    logic           r_busy;
    logic           r_err;
    logic           r_first;
    logic [LW-1:0]  r_cnt;
`ifndef DMA_WR_ARB_PRIO_EN
    logic [IW-1:0]  r_ptr;
`endif

    logic [LW-1:0]  w_len;
    logic [AW-1:0]  w_addr;
    logic [DW-1:0]  w_data;
    logic           w_val;
    logic           w_hs;
    logic           w_last;
    logic [IW-1:0]  w_win;

    assign w_len  = arb_if.m_wlen[r_gidx*LW +: LW];
    assign w_addr = arb_if.m_waddr[r_gidx*AW +: AW];
    assign w_data = arb_if.m_wdata[r_gidx*DW +: DW];
    assign w_val  = arb_if.m_wval[r_gidx];

    assign arb_if.bus_wval  = r_busy & w_val;
    assign arb_if.bus_wlen  = r_busy ? w_len  : '0;
    assign arb_if.bus_waddr = r_busy ? w_addr : '0;
    assign arb_if.bus_wdata = r_busy ? w_data : '0;
    assign arb_if.m_wrdy    = r_gnt & {NR{arb_if.bus_wrdy}};

    assign arb_gnt  = r_gnt;
    assign arb_busy = r_busy;
    assign arb_err  = r_err;

    assign w_hs = arb_if.bus_wval & arb_if.bus_wrdy;
    // r_cnt holds beats still owed after the first; the beat that empties it is the last
    assign w_last = r_first ? (w_len <= LW'(1)) : (r_cnt == LW'(1));

    // Scanning downward lets the nearest candidate above the pointer overwrite the rest
    always_comb begin
        w_win = '0;
`ifdef DMA_WR_ARB_PRIO_EN
        for (int unsigned k = NR; k > 0; k--) begin
            if (arb_if.m_wval[k-1]) w_win = IW'(k-1);
        end
`else
        for (int unsigned k = NR; k > 0; k--) begin
            if (arb_if.m_wval[(32'(r_ptr) + k) % NR]) w_win = IW'((32'(r_ptr) + k) % NR);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_gidx  <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_first <= 1'b0;
            r_cnt   <= '0;
`ifndef DMA_WR_ARB_PRIO_EN
            r_ptr   <= IW'(NR-1);
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|arb_if.m_wval) begin
                        r_gnt   <= NR'(1) << w_win;
                        r_gidx  <= w_win;
                        r_busy  <= 1'b1;
                        r_first <= 1'b1;
                        r_state <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (w_hs) begin
                        if (r_first) begin
                            r_first <= 1'b0;
                            if (w_len == '0) r_err <= 1'b1;
                            r_cnt <= (w_len == '0) ? '0 : w_len - LW'(1);
                        end else begin
                            r_cnt <= r_cnt - LW'(1);
                        end
                        if (w_last) begin
                            r_gnt   <= '0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
`ifndef DMA_WR_ARB_PRIO_EN
                            r_ptr   <= r_gidx;
`endif
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
